control_sequencer: RTL and testbench

Top-level sequencer of the multi-cycle control unit. Classifies the fetched instruction into a format, selects that format's 33-bit control word from the per-format logic blocks, and holds the 2-bit state register, instruction register and NZCV status register. Inserts RAM wait states via a ready handshake, halts on illegal opcodes and counts retired instructions. Sits between the instruction memory and format logic blocks on one side and the datapath control bus on the other.

---
 rtl/control_pkg.sv | 55 +++++
 rtl/control_sequencer_if.sv | 32 +++
 rtl/format_classifier.sv | 23 ++
 rtl/control_sequencer.sv | 97 +++++++++
 tb/tb_control_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle control unit: control word layout,
// format codes, state encodings and opcode match patterns.
package control_pkg;

    localparam int unsigned CW_W    = 33;
    localparam int unsigned RET_W   = 16;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FMT_W   = 3;
    localparam int unsigned ST_W    = 2;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned OPC_W   = 10;   // instruction[31:22], all the classifier needs
    localparam int unsigned OPC_LSB = 22;

    // Control word field positions, lsb upward
    localparam int unsigned NS_LSB          = 0;
    localparam int unsigned NS_W            = 2;
    localparam int unsigned STATUS_LOAD_BIT = 2;
    localparam int unsigned PC_SEL_BIT      = 3;
    localparam int unsigned PC_FS_LSB       = 4;
    localparam int unsigned PC_FS_W         = 2;
    localparam int unsigned PC_EN_BIT       = 6;
    localparam int unsigned RAM_W_BIT       = 7;
    localparam int unsigned RAM_EN_BIT      = 8;
    localparam int unsigned REG_W_BIT       = 9;
    localparam int unsigned WA_LSB          = 10;
    localparam int unsigned SB_LSB          = 15;
    localparam int unsigned SA_LSB          = 20;
    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned RFB_EN_BIT      = 25;
    localparam int unsigned ALU_FS_LSB      = 26;
    localparam int unsigned ALU_FS_W        = 5;
    localparam int unsigned ALU_BS_BIT      = 31;
    localparam int unsigned ALU_EN_BIT      = 32;

    localparam logic [CW_W-1:0] CW_NOP = '0;

    localparam logic [FMT_W-1:0] FMT_R   = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I   = 3'd1;
    localparam logic [FMT_W-1:0] FMT_D   = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B   = 3'd3;
    localparam logic [FMT_W-1:0] FMT_CB  = 3'd4;
    localparam logic [FMT_W-1:0] FMT_ILL = 3'd7;

    localparam logic [ST_W-1:0] S0 = 2'b00;
    localparam logic [ST_W-1:0] S1 = 2'b01;
    localparam logic [ST_W-1:0] S2 = 2'b10;
    localparam logic [ST_W-1:0] S3 = 2'b11;

    // D matches both 1111100001 and 1111100000, so only the top nine bits are compared
    localparam logic [5:0] OPC_B  = 6'b000101;
    localparam logic [6:0] OPC_CB = 7'b1011010;
    localparam logic [8:0] OPC_D  = 9'b111110000;
    localparam logic [2:0] OPC_I  = 3'b100;

endpackage

// File: rtl/control_sequencer_if.sv
// Bus between the sequencer, instruction memory / format logic and datapath.
interface control_sequencer_if;
    import control_pkg::*;

    logic [INSTR_W-1:0] instruction;
    logic [CW_W-1:0]    cw_r;
    logic [CW_W-1:0]    cw_i;
    logic [CW_W-1:0]    cw_d;
    logic [CW_W-1:0]    cw_b;
    logic [CW_W-1:0]    cw_cb;
    logic [FLAG_W-1:0]  alu_status;
    logic               alu_zero;
    logic               ram_ready;
    logic [ST_W-1:0]    state;
    logic [FLAG_W:0]    status;
    logic [INSTR_W-1:0] inst_out;
    logic [CW_W-1:0]    control_word;
    logic [FMT_W-1:0]   format;
    logic               illegal;
    logic [RET_W-1:0]   retired;

    modport slave (
        input  instruction, cw_r, cw_i, cw_d, cw_b, cw_cb, alu_status, alu_zero, ram_ready,
        output state, status, inst_out, control_word, format, illegal, retired
    );

    modport master (
        output instruction, cw_r, cw_i, cw_d, cw_b, cw_cb, alu_status, alu_zero, ram_ready,
        input  state, status, inst_out, control_word, format, illegal, retired
    );

endinterface

// File: rtl/format_classifier.sv
// Combinational opcode -> instruction format, in fixed priority order.
module format_classifier
    import control_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,   // instruction[31:22]
    output logic [FMT_W-1:0] o_format
);

    always_comb begin
        o_format = FMT_ILL;
        if (i_opcode[9:4] == OPC_B)
            o_format = FMT_B;
        else if (i_opcode[9:3] == OPC_CB)
            o_format = FMT_CB;
        else if (i_opcode[9:1] == OPC_D)
            o_format = FMT_D;
        else if (i_opcode[6:4] == OPC_I)
            o_format = FMT_I;
        else if (i_opcode[5] && !i_opcode[3])
            o_format = FMT_R;
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: format select, RAM wait-state stall,
// illegal-opcode halt, NZCV latch and retired-instruction counter.
module control_sequencer
    import control_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    control_sequencer_if.slave bus
);

    logic [ST_W-1:0]    r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [FMT_W-1:0]   r_fmt;
    logic [FLAG_W-1:0]  r_status;
    logic               r_illegal;
    logic [RET_W-1:0]   r_retired;

    logic [FMT_W-1:0]   w_class;
    logic [FMT_W-1:0]   w_fmt;
    logic               w_fetch;
    logic               w_new_illegal;
    logic               w_halt;
    logic               w_stall;
    logic [CW_W-1:0]    w_sel;
    logic [CW_W-1:0]    w_cw;

    format_classifier u_classifier (
        .i_opcode (bus.instruction[INSTR_W-1:OPC_LSB]),
        .o_format (w_class)
    );

    // Format selection, halt masking and stall masking of the control word
    always_comb begin
        w_sel         = CW_NOP;
        w_cw          = CW_NOP;
        w_stall       = 1'b0;
        w_fetch       = (r_state == S0);
        w_fmt         = w_fetch ? w_class : r_fmt;
        w_new_illegal = w_fetch && (w_class == FMT_ILL);
        w_halt        = reset || r_illegal || w_new_illegal;

        case (w_fmt)
            FMT_R:   w_sel = bus.cw_r;
            FMT_I:   w_sel = bus.cw_i;
            FMT_D:   w_sel = bus.cw_d;
            FMT_B:   w_sel = bus.cw_b;
            FMT_CB:  w_sel = bus.cw_cb;
            default: w_sel = CW_NOP;   // corrupt fmt_reg: NOP carries NS=00
        endcase

        if (!w_halt) begin
            w_cw    = w_sel;
            w_stall = (w_sel[RAM_EN_BIT] || w_sel[RAM_W_BIT]) && !bus.ram_ready;
            // Keep RAM strobes and addresses, suppress every architectural update
            if (w_stall) begin
                w_cw[REG_W_BIT]              = 1'b0;
                w_cw[STATUS_LOAD_BIT]        = 1'b0;
                w_cw[PC_FS_LSB +: PC_FS_W]   = 2'b00;
                w_cw[NS_LSB +: NS_W]         = r_state;
            end
        end
    end

    // State, instruction, status and retire bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S0;
            r_ir      <= '0;
            r_fmt     <= FMT_R;
            r_status  <= '0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else if (w_new_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= S0;
        end else if (!w_stall) begin
            r_state <= w_cw[NS_LSB +: NS_W];
            if (w_fetch && !r_illegal) begin
                r_ir  <= bus.instruction;
                r_fmt <= w_class;
            end
            if (w_cw[STATUS_LOAD_BIT])
                r_status <= bus.alu_status;
            if ((w_cw[NS_LSB +: NS_W] == S0) && !r_illegal)
                r_retired <= r_retired + RET_W'(1);
        end
    end

    assign bus.state        = r_state;
    assign bus.status       = {bus.alu_zero, r_status};
    assign bus.inst_out     = w_fetch ? bus.instruction : r_ir;
    assign bus.control_word = w_cw;
    assign bus.format       = w_fmt;
    assign bus.illegal      = r_illegal;
    assign bus.retired      = r_retired;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with hand-computed expectations.
module tb_control_sequencer;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] INS_ADDI = 32'h9100_0000;
    localparam logic [31:0] INS_LDUR = 32'hF840_0000;
    localparam logic [31:0] INS_CBZ  = 32'hB400_0000;
    localparam logic [31:0] INS_B    = 32'h1400_0000;
    localparam logic [31:0] INS_R    = 32'h8800_0000;

    // Control word built field by field: alu_en, bs, fs, rfb_en, sa, sb, wa, reg_w,
    // ram_en, ram_w, pc_en, pc_fs, pc_sel, status_load, NS
    function automatic logic [32:0] mkcw(input logic [4:0] wa, input logic regw,
                                         input logic ram_en, input logic [1:0] pcfs,
                                         input logic sl, input logic [1:0] ns);
        return {1'b1, 1'b0, 5'd3, 1'b1, 5'd7, 5'd9, wa, regw, ram_en, 1'b0, 1'b1,
                pcfs, 1'b0, sl, ns};
    endfunction

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [32:0] cw_d0;
    logic [32:0] cw_d1;

    initial begin
        clock   = 1'b0;
        reset   = 1'b1;
        n_tests = 0;
        n_fail  = 0;
        cw_d0   = mkcw(5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01);
        cw_d1   = mkcw(5'd4, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
        bus.instruction = INS_ADDI;
        bus.cw_r        = mkcw(5'd1, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00);
        bus.cw_i        = mkcw(5'd2, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00);
        bus.cw_d        = cw_d0;
        bus.cw_b        = mkcw(5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
        bus.cw_cb       = mkcw(5'd0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00);
        bus.alu_status  = 4'b0000;
        bus.alu_zero    = 1'b0;
        bus.ram_ready   = 1'b1;

        // Reset
        #2;
        check("reset_cw_nop", bus.control_word, 33'd0);
        step();
        step();
        check("reset_cw_nop2", bus.control_word, 33'd0);
        reset = 1'b0;
        check("reset_state", 33'(bus.state), 33'd0);
        check("reset_retired", 33'(bus.retired), 33'd0);
        check("reset_illegal", 33'(bus.illegal), 33'd0);
        check("reset_status", 33'(bus.status), 33'd0);

        // Reset in the middle of a multi-cycle instruction
        bus.instruction = INS_LDUR;
        #1;
        check("mid_fmt_d", 33'(bus.format), 33'd2);
        check("mid_cw_d0", bus.control_word, cw_d0);
        step();
        check("mid_state01", 33'(bus.state), 33'd1);
        reset = 1'b1;
        #1;
        check("mid_reset_nop", bus.control_word, 33'd0);
        step();
        reset = 1'b0;
        check("mid_state00", 33'(bus.state), 33'd0);
        check("mid_no_retire", 33'(bus.retired), 33'd0);

        // ADDI with status load
        bus.instruction = INS_ADDI;
        bus.alu_status  = 4'b0100;
        #1;
        check("addi_fmt", 33'(bus.format), 33'd1);
        check("addi_cw", bus.control_word, bus.cw_i);
        check("addi_inst_out", 33'(bus.inst_out), 33'(INS_ADDI));
        step();
        check("addi_status", 33'(bus.status), 33'(5'b00100));
        check("addi_retired", 33'(bus.retired), 33'd1);
        check("addi_state", 33'(bus.state), 33'd0);
        bus.alu_status = 4'b1011;

        // LDUR with three RAM wait states
        bus.instruction = INS_LDUR;
        bus.cw_d        = cw_d0;
        bus.ram_ready   = 1'b0;
        step();
        check("ldur_state01", 33'(bus.state), 33'd1);
        bus.instruction = 32'h0;
        bus.cw_d        = cw_d1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ldur_stall_cw", bus.control_word, mkcw(5'd4, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01));
            check("ldur_ir", 33'(bus.inst_out), 33'(INS_LDUR));
            check("ldur_fmt_reg", 33'(bus.format), 33'd2);
            step();
            check("ldur_hold01", 33'(bus.state), 33'd1);
            check("ldur_hold_ret", 33'(bus.retired), 33'd1);
        end
        bus.ram_ready = 1'b1;
        #1;
        check("ldur_ready_cw", bus.control_word, cw_d1);
        step();
        check("ldur_done_state", 33'(bus.state), 33'd0);
        check("ldur_retired", 33'(bus.retired), 33'd2);
        check("ldur_status_kept", 33'(bus.status), 33'(5'b00100));

        // CBZ with live zero flag
        bus.instruction = INS_CBZ;
        bus.alu_zero    = 1'b1;
        #1;
        check("cbz_fmt", 33'(bus.format), 33'd4);
        check("cbz_cw", bus.control_word, bus.cw_cb);
        check("cbz_zero1", 33'(bus.status[4]), 33'd1);
        bus.alu_zero = 1'b0;
        #1;
        check("cbz_zero0", 33'(bus.status[4]), 33'd0);
        step();
        check("cbz_retired", 33'(bus.retired), 33'd3);

        // B and R formats
        bus.instruction = INS_B;
        #1;
        check("b_fmt", 33'(bus.format), 33'd3);
        check("b_cw", bus.control_word, bus.cw_b);
        step();
        bus.instruction = INS_R;
        #1;
        check("r_fmt", 33'(bus.format), 33'd0);
        check("r_cw", bus.control_word, bus.cw_r);
        step();
        check("br_retired", 33'(bus.retired), 33'd5);

        // Illegal opcode halts the sequencer
        bus.instruction = 32'h0;
        #1;
        check("ill_fmt", 33'(bus.format), 33'd7);
        check("ill_cw_nop", bus.control_word, 33'd0);
        step();
        check("ill_flag", 33'(bus.illegal), 33'd1);
        check("ill_state", 33'(bus.state), 33'd0);
        check("ill_no_retire", 33'(bus.retired), 33'd5);
        bus.instruction = INS_ADDI;
        #1;
        check("halt_cw_nop", bus.control_word, 33'd0);
        step();
        check("halt_flag", 33'(bus.illegal), 33'd1);
        check("halt_retired", 33'(bus.retired), 33'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("halt_cleared", 33'(bus.illegal), 33'd0);

        // Retired counter wrap
        bus.instruction = INS_ADDI;
        repeat (65535) step();
        check("wrap_ffff", 33'(bus.retired), 33'h0FFFF);
        step();
        check("wrap_zero", 33'(bus.retired), 33'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
